// File: rtl/dds_cfg_pkg.sv
// rtl/dds_cfg_pkg.sv - shared constants, opcodes and FSM state type for the DDS command controller
package dds_cfg_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam logic [7:0] OP_SET_FWORD = 8'h10;
  localparam logic [7:0] OP_SET_PHASE = 8'h11;
  localparam logic [7:0] OP_SET_EN    = 8'h12;
  localparam logic [7:0] OP_COMMIT    = 8'h20;
  localparam logic [7:0] OP_READ_STAT = 8'h30;

  localparam logic [2:0] LEN_SET_FWORD = 3'd4;
  localparam logic [2:0] LEN_SET_PHASE = 3'd2;
  localparam logic [2:0] LEN_SET_EN    = 3'd1;
  localparam logic [2:0] LEN_NONE      = 3'd0;

  localparam logic [7:0] ACK_BYTE = 8'h5A;
  localparam logic [7:0] NAK_BYTE = 8'hEE;
  localparam logic [7:0] TX_RST   = 8'hC3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_PAYLOAD,
    ST_CHECK
  } state_t;

  function automatic logic op_known(input logic [7:0] op);
    return (op == OP_SET_FWORD) || (op == OP_SET_PHASE) || (op == OP_SET_EN) ||
           (op == OP_COMMIT) || (op == OP_READ_STAT);
  endfunction

  function automatic logic [2:0] op_len(input logic [7:0] op);
    case (op)
      OP_SET_FWORD: return LEN_SET_FWORD;
      OP_SET_PHASE: return LEN_SET_PHASE;
      OP_SET_EN:    return LEN_SET_EN;
      default:      return LEN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dds_byte_sync.sv
// rtl/dds_byte_sync.sv - synchronises the SPI byte flag and emits a one-cycle byte strobe
module dds_byte_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_flag,
  input  logic [7:0] i_rx_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte
);

  logic r_sync1, r_sync2, r_sync3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_rx_flag;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // rx_data is held stable by the SPI slave while the flag is high, so it is
  // safe to sample directly in the strobe cycle.
  assign o_byte_valid = r_sync2 & ~r_sync3;
  assign o_byte       = i_rx_data;

endmodule

// File: rtl/dds_cmd_ctrl.sv
// rtl/dds_cmd_ctrl.sv - framed SPI command parser with shadowed, atomically committed DDS settings
module dds_cmd_ctrl #(
  parameter int FWORD_W     = 32,
  parameter int PHASE_W     = 12,
  parameter int TIMEOUT_CYC = 30000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_flag,
  input  logic [7:0]         rx_data,
  output logic [7:0]         tx_data,
  output logic [FWORD_W-1:0] fword,
  output logic [PHASE_W-1:0] phase_off,
  output logic               out_en,
  output logic               cfg_update,
  output logic [7:0]         err_cnt,
  output logic               busy
);
  import dds_cfg_pkg::*;

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic               w_bv;
  logic [7:0]         w_byte;
  state_t             r_state, w_state_nxt;
  logic               w_ok, w_bad, w_tmo_fire;
  logic [7:0]         r_op, r_xor;
  logic [2:0]         r_len;
  logic [31:0]        r_stage;
  logic [FWORD_W-1:0] r_sh_fword;
  logic [PHASE_W-1:0] r_sh_phase;
  logic               r_sh_en, r_dirty;
  logic [TMO_W-1:0]   r_tmo;

  dds_byte_sync u_sync (
    .clk          (clk),
    .rst          (rst),
    .i_rx_flag    (rx_flag),
    .i_rx_data    (rx_data),
    .o_byte_valid (w_bv),
    .o_byte       (w_byte)
  );

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign w_tmo_fire = (r_state != ST_IDLE) && !w_bv && (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
  assign busy       = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ok        = 1'b0;
    w_bad       = 1'b0;
    if (w_tmo_fire) begin
      w_state_nxt = ST_IDLE;
      w_bad       = 1'b1;
    end else if (w_bv) begin
      case (r_state)
        ST_IDLE:    if (w_byte == SYNC_BYTE) w_state_nxt = ST_CMD;
        ST_CMD: begin
          if (!op_known(w_byte)) begin
            w_state_nxt = ST_IDLE;
            w_bad       = 1'b1;
          end else if (op_len(w_byte) != LEN_NONE) begin
            w_state_nxt = ST_PAYLOAD;
          end else begin
            w_state_nxt = ST_CHECK;
          end
        end
        ST_PAYLOAD: if (r_len == 3'd1) w_state_nxt = ST_CHECK;
        ST_CHECK: begin
          w_state_nxt = ST_IDLE;
          if (w_byte == r_xor) w_ok  = 1'b1;
          else                 w_bad = 1'b1;
        end
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op       <= '0;
      r_xor      <= '0;
      r_len      <= '0;
      r_stage    <= '0;
      r_sh_fword <= '0;
      r_sh_phase <= '0;
      r_sh_en    <= 1'b0;
      r_dirty    <= 1'b0;
      r_tmo      <= '0;
      fword      <= '0;
      phase_off  <= '0;
      out_en     <= 1'b0;
      cfg_update <= 1'b0;
      err_cnt    <= '0;
      tx_data    <= TX_RST;
    end else begin
      cfg_update <= 1'b0;
      if (w_bv || r_state == ST_IDLE) r_tmo <= '0;
      else                            r_tmo <= r_tmo + 1'b1;

      if (w_bv && r_state == ST_CMD) begin
        r_op    <= w_byte;
        r_len   <= op_len(w_byte);
        r_xor   <= w_byte;
        r_stage <= '0;
      end else if (w_bv && r_state == ST_PAYLOAD) begin
        // LSB-first: after N shifts the payload sits in the top N bytes.
        r_stage <= {w_byte, r_stage[31:8]};
        r_xor   <= r_xor ^ w_byte;
        r_len   <= r_len - 1'b1;
      end

      if (w_bad) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
        tx_data <= NAK_BYTE;
      end

      if (w_ok) begin
        tx_data <= ACK_BYTE;
        case (r_op)
          OP_SET_FWORD: begin
            r_sh_fword <= r_stage[FWORD_W-1:0];
            r_dirty    <= 1'b1;
          end
          OP_SET_PHASE: begin
            r_sh_phase <= r_stage[16 +: PHASE_W];
            r_dirty    <= 1'b1;
          end
          OP_SET_EN: begin
            r_sh_en <= r_stage[24];
            r_dirty <= 1'b1;
          end
          OP_COMMIT: begin
            fword      <= r_sh_fword;
            phase_off  <= r_sh_phase;
            out_en     <= r_sh_en;
            cfg_update <= 1'b1;
            r_dirty    <= 1'b0;
          end
          OP_READ_STAT: tx_data <= {out_en, r_dirty, 2'b00, err_cnt[3:0]};
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_cmd_ctrl.sv
// tb/tb_dds_cmd_ctrl.sv - directed self-checking bench for dds_cmd_ctrl
module tb_dds_cmd_ctrl;

  localparam int TMO = 30000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_flag = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [7:0]  tx_data;
  logic [31:0] fword;
  logic [11:0] phase_off;
  logic        out_en;
  logic        cfg_update;
  logic [7:0]  err_cnt;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  int p0;

  dds_cmd_ctrl #(.FWORD_W(32), .PHASE_W(12), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_flag    (rx_flag),
    .rx_data    (rx_data),
    .tx_data    (tx_data),
    .fword      (fword),
    .phase_off  (phase_off),
    .out_en     (out_en),
    .cfg_update (cfg_update),
    .err_cnt    (err_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cfg_update === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    #3 rx_flag = 1'b1;
    repeat (6) @(posedge clk);
    #3 rx_flag = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_fword", fword, 32'h0);
    check("rst_phase", {20'h0, phase_off}, 32'h0);
    check("rst_out_en", {31'h0, out_en}, 32'h0);
    check("rst_tx", {24'h0, tx_data}, 32'hC3);
    check("rst_err", {24'h0, err_cnt}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);

    // SET_FWORD C5B0A805, checksum 10^05^A8^B0^C5 = C8
    send3(8'hA5, 8'h10, 8'h05);
    send3(8'hA8, 8'hB0, 8'hC5);
    send_byte(8'hC8);
    check("setf_tx", {24'h0, tx_data}, 32'h5A);
    check("setf_not_active", fword, 32'h0);
    p0 = pulses;
    send3(8'hA5, 8'h20, 8'h20);
    check("commit_fword", fword, 32'hC5B0A805);
    check("commit_pulses", pulses - p0, 32'd1);
    check("commit_tx", {24'h0, tx_data}, 32'h5A);

    // bad checksum on SET_EN
    send3(8'hA5, 8'h12, 8'h01);
    send_byte(8'h00);
    check("badchk_err", {24'h0, err_cnt}, 32'd1);
    check("badchk_tx", {24'h0, tx_data}, 32'hEE);
    send3(8'hA5, 8'h30, 8'h30);
    check("badchk_status", {24'h0, tx_data}, 32'h01);
    send3(8'hA5, 8'h20, 8'h20);
    check("badchk_commit_en", {31'h0, out_en}, 32'h0);

    // timeout mid SET_PHASE
    send3(8'hA5, 8'h11, 8'h34);
    repeat (TMO - 60) @(negedge clk);
    check("tmo_not_early", {31'h0, busy}, 32'h1);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check("tmo_busy", {31'h0, busy}, 32'h0);
    check("tmo_err", {24'h0, err_cnt}, 32'd2);
    check("tmo_tx", {24'h0, tx_data}, 32'hEE);
    send3(8'hA5, 8'h30, 8'h30);
    check("tmo_status", {24'h0, tx_data}, 32'h02);

    // A5 as payload data, then phase and enable
    send3(8'hA5, 8'h10, 8'hA5);
    send3(8'h01, 8'h02, 8'h03);
    send_byte(8'hB5);
    check("a5data_tx", {24'h0, tx_data}, 32'h5A);
    send3(8'hA5, 8'h11, 8'h34);
    send_byte(8'hF2);
    send_byte(8'hD7);
    send3(8'hA5, 8'h12, 8'h01);
    send_byte(8'h13);
    send3(8'hA5, 8'h30, 8'h30);
    check("dirty_status", {24'h0, tx_data}, 32'h42);
    check("phase_held", {20'h0, phase_off}, 32'h0);
    p0 = pulses;
    send3(8'hA5, 8'h20, 8'h20);
    check("a5data_fword", fword, 32'h030201A5);
    check("phase_active", {20'h0, phase_off}, 32'h234);
    check("en_active", {31'h0, out_en}, 32'h1);
    check("commit2_pulses", pulses - p0, 32'd1);
    send3(8'hA5, 8'h30, 8'h30);
    check("clean_status", {24'h0, tx_data}, 32'h82);

    // unknown opcode
    send_byte(8'hA5);
    send_byte(8'h77);
    check("unk_tx", {24'h0, tx_data}, 32'hEE);
    check("unk_err", {24'h0, err_cnt}, 32'd3);
    check("unk_busy", {31'h0, busy}, 32'h0);

    // saturation
    for (int i = 0; i < 256; i++) begin
      send_byte(8'hA5);
      send_byte(8'h77);
    end
    check("sat_err", {24'h0, err_cnt}, 32'd255);
    check("sat_fword_kept", fword, 32'h030201A5);

    // async reset after two payload bytes
    send3(8'hA5, 8'h10, 8'h11);
    send_byte(8'h22);
    #2 rst = 1'b0;
    #1;
    check("mrst_fword", fword, 32'h0);
    check("mrst_phase", {20'h0, phase_off}, 32'h0);
    check("mrst_out_en", {31'h0, out_en}, 32'h0);
    check("mrst_tx", {24'h0, tx_data}, 32'hC3);
    check("mrst_err", {24'h0, err_cnt}, 32'h0);
    check("mrst_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    send3(8'hA5, 8'h12, 8'h01);
    send_byte(8'h13);
    check("post_rst_tx", {24'h0, tx_data}, 32'h5A);
    p0 = pulses;
    send3(8'hA5, 8'h20, 8'h20);
    check("post_rst_en", {31'h0, out_en}, 32'h1);
    check("post_rst_pulses", pulses - p0, 32'd1);
    check("post_rst_fword", fword, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
